// File: rtl/auth_engine_pkg.sv
// Shared definitions for the ATM account authenticator: response encodings,
// FSM state encoding and the power-on PIN table.
package auth_engine_pkg;

  localparam logic ACCOUNT_FOUND             = 1'b1;
  localparam logic ACCOUNT_NOT_FOUND         = 1'b0;
  localparam logic ACCOUNT_AUTHENTICATED     = 1'b1;
  localparam logic ACCOUNT_NOT_AUTHENTICATED = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    CHECK,
    RESP,
    CHANGE
  } state_t;

  // PINs are four keypad digits packed as BCD nibbles.
  function automatic logic [15:0] default_pin(input int unsigned idx);
    case (idx)
      0:       default_pin = 16'h1234;
      1:       default_pin = 16'h2345;
      2:       default_pin = 16'h3456;
      3:       default_pin = 16'h4567;
      4:       default_pin = 16'h5678;
      5:       default_pin = 16'h6789;
      6:       default_pin = 16'h7890;
      7:       default_pin = 16'h8901;
      8:       default_pin = 16'h9012;
      9:       default_pin = 16'h7123;
      default: default_pin = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/auth_fail_tracker.sv
// Per-account saturating consecutive-failure counters with lock flags.
module auth_fail_tracker
  import auth_engine_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 10,
  parameter int MAX_TRIES    = 3,
  parameter int IDX_W        = $clog2(NUM_ACCOUNTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_en,
  input  logic [IDX_W-1:0]        clear_idx,
  input  logic                    inc_en,
  input  logic [IDX_W-1:0]        inc_idx,
  input  logic                    unlock_en,
  input  logic [IDX_W-1:0]        unlock_idx,
  output logic [NUM_ACCOUNTS-1:0] locked,
  output logic                    inc_locks
);

  localparam int CNT_W = $clog2(MAX_TRIES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRIES);

  logic [CNT_W-1:0] fail_cnt [NUM_ACCOUNTS];

  // Tells the caller whether the increment it is requesting will lock the account.
  assign inc_locks = inc_en && (fail_cnt[inc_idx] >= MAX_CNT - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) fail_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        if (unlock_en && unlock_idx == IDX_W'(i)) begin
          fail_cnt[i] <= '0;
          locked[i]   <= 1'b0;
        end else if (clear_en && clear_idx == IDX_W'(i)) begin
          fail_cnt[i] <= '0;
        end else if (inc_en && inc_idx == IDX_W'(i) && fail_cnt[i] < MAX_CNT) begin
          fail_cnt[i] <= fail_cnt[i] + CNT_W'(1);
          if (fail_cnt[i] >= MAX_CNT - CNT_W'(1)) locked[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/auth_engine.sv
// Sequential account/PIN authenticator with lockout and PIN-change session.
// Optional admin unlock port pair is enabled with `define ADMIN_UNLOCK_EN.
module auth_engine
  import auth_engine_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 10,
  parameter int ACC_W        = 4,
  parameter int PIN_W        = 16,
  parameter int MAX_TRIES    = 3,
  parameter int IDX_W        = $clog2(NUM_ACCOUNTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ACC_W-1:0] req_acc_num,
  input  logic [PIN_W-1:0] req_pin,
  input  logic             chg_valid,
  input  logic [PIN_W-1:0] chg_new_pin,
  input  logic             logout,
`ifdef ADMIN_UNLOCK_EN
  input  logic             unlock_valid,
  input  logic [IDX_W-1:0] unlock_idx,
`endif
  output logic             rsp_valid,
  output logic             rsp_found,
  output logic             rsp_auth,
  output logic             rsp_locked,
  output logic [IDX_W-1:0] rsp_index,
  output logic             chg_done,
  output logic             chg_ok,
  output logic             session_active,
  output logic [IDX_W-1:0] session_idx
);

  state_t state, next_state;

  logic [ACC_W-1:0]        acc_q;
  logic [PIN_W-1:0]        pin_q;
  logic [PIN_W-1:0]        new_pin_q;
  logic [IDX_W-1:0]        scan_idx;
  logic                    found_q;
  logic [PIN_W-1:0]        pin_db [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] locked;
  logic                    inc_locks;
  logic                    idle_go, accept, chg_accept, match, last_idx;
  logic                    pin_ok, entry_locked, auth_pass, auth_fail, chg_allowed;
  logic                    unlock_en;
  logic [IDX_W-1:0]        unlock_sel;

  assign idle_go      = (state == IDLE) && req_ready;
  assign accept       = idle_go && req_valid;
  assign chg_accept   = idle_go && !req_valid && chg_valid;
  assign match        = (acc_q == ACC_W'(scan_idx) + ACC_W'(1));
  assign last_idx     = (scan_idx == IDX_W'(NUM_ACCOUNTS - 1));
  assign pin_ok       = (pin_db[scan_idx] == pin_q);
  assign entry_locked = locked[scan_idx];
  assign auth_pass    = (state == CHECK) && found_q && !entry_locked && pin_ok;
  assign auth_fail    = (state == CHECK) && found_q && !entry_locked && !pin_ok;
  assign chg_allowed  = session_active && !logout && (new_pin_q != pin_db[session_idx]);

`ifdef ADMIN_UNLOCK_EN
  assign unlock_en  = idle_go && !req_valid && !chg_valid && unlock_valid &&
                      ({1'b0, unlock_idx} < (IDX_W + 1)'(NUM_ACCOUNTS));
  assign unlock_sel = unlock_idx;
`else
  assign unlock_en  = 1'b0;
  assign unlock_sel = '0;
`endif

  auth_fail_tracker #(
    .NUM_ACCOUNTS (NUM_ACCOUNTS),
    .MAX_TRIES    (MAX_TRIES),
    .IDX_W        (IDX_W)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_en   (auth_pass),
    .clear_idx  (scan_idx),
    .inc_en     (auth_fail),
    .inc_idx    (scan_idx),
    .unlock_en  (unlock_en),
    .unlock_idx (unlock_sel),
    .locked     (locked),
    .inc_locks  (inc_locks)
  );

  // Ready is registered so that it reads 0 while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == IDLE);
    end
  end

  // A miss at the last index still passes through CHECK, so a miss costs the
  // same latency as a hit on the final entry.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SEARCH;
               else if (chg_accept) next_state = CHANGE;
      SEARCH:  if (match || last_idx) next_state = CHECK;
      CHECK:   next_state = RESP;
      RESP:    next_state = IDLE;
      CHANGE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q          <= '0;
      pin_q          <= '0;
      new_pin_q      <= '0;
      scan_idx       <= '0;
      found_q        <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_found      <= ACCOUNT_NOT_FOUND;
      rsp_auth       <= ACCOUNT_NOT_AUTHENTICATED;
      rsp_locked     <= 1'b0;
      rsp_index      <= '0;
      chg_done       <= 1'b0;
      chg_ok         <= 1'b0;
      session_active <= 1'b0;
      session_idx    <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) pin_db[i] <= PIN_W'(default_pin(i));
    end else begin
      rsp_valid <= (state == CHECK);
      chg_done  <= (state == CHANGE);
      chg_ok    <= (state == CHANGE) && chg_allowed;
      case (state)
        IDLE: begin
          if (accept) begin
            acc_q          <= req_acc_num;
            pin_q          <= req_pin;
            scan_idx       <= '0;
            found_q        <= 1'b0;
            session_active <= 1'b0;
            session_idx    <= '0;
          end else if (chg_accept) begin
            new_pin_q <= chg_new_pin;
          end
        end
        SEARCH: begin
          if (match) found_q <= 1'b1;
          else if (!last_idx) scan_idx <= scan_idx + IDX_W'(1);
        end
        CHECK: begin
          rsp_found  <= found_q ? ACCOUNT_FOUND : ACCOUNT_NOT_FOUND;
          rsp_auth   <= auth_pass ? ACCOUNT_AUTHENTICATED : ACCOUNT_NOT_AUTHENTICATED;
          rsp_locked <= found_q && (entry_locked || inc_locks);
          rsp_index  <= found_q ? scan_idx : '0;
          if (auth_pass) begin
            session_active <= 1'b1;
            session_idx    <= scan_idx;
          end
        end
        CHANGE: begin
          if (chg_allowed) pin_db[session_idx] <= new_pin_q;
        end
        default: ;
      endcase
      if (logout) begin
        session_active <= 1'b0;
        session_idx    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_auth_engine.sv
// Directed self-checking bench for auth_engine (default parameters).
// Define ADMIN_UNLOCK_EN to also exercise the admin unlock ports.
module tb_auth_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_acc_num = '0;
  logic [15:0] req_pin = '0;
  logic        chg_valid = 1'b0;
  logic [15:0] chg_new_pin = '0;
  logic        logout = 1'b0;
`ifdef ADMIN_UNLOCK_EN
  logic        unlock_valid = 1'b0;
  logic [3:0]  unlock_idx = '0;
`endif
  logic        rsp_valid, rsp_found, rsp_auth, rsp_locked;
  logic [3:0]  rsp_index;
  logic        chg_done, chg_ok, session_active;
  logic [3:0]  session_idx;

  int testCount = 0;
  int failCount = 0;
  int rspCount  = 0;
  int chgCount  = 0;

  auth_engine dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_acc_num    (req_acc_num),
    .req_pin        (req_pin),
    .chg_valid      (chg_valid),
    .chg_new_pin    (chg_new_pin),
    .logout         (logout),
`ifdef ADMIN_UNLOCK_EN
    .unlock_valid   (unlock_valid),
    .unlock_idx     (unlock_idx),
`endif
    .rsp_valid      (rsp_valid),
    .rsp_found      (rsp_found),
    .rsp_auth       (rsp_auth),
    .rsp_locked     (rsp_locked),
    .rsp_index      (rsp_index),
    .chg_done       (chg_done),
    .chg_ok         (chg_ok),
    .session_active (session_active),
    .session_idx    (session_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) rspCount++;
    if (chg_done === 1'b1) chgCount++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Issue one request and check latency (accept edge counts as cycle 1) and result.
  task automatic applyStimulus(input logic [3:0] acc, input logic [15:0] pin,
                               input int expLat, input logic expFound,
                               input logic expAuth, input logic expLocked,
                               input logic [3:0] expIdx);
    int cyc;
    @(negedge clk);
    req_acc_num = acc;
    req_pin     = pin;
    req_valid   = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    checkOutput("latency", cyc, expLat);
    checkOutput("rsp_found", rsp_found, expFound);
    checkOutput("rsp_auth", rsp_auth, expAuth);
    checkOutput("rsp_locked", rsp_locked, expLocked);
    checkOutput("rsp_index", rsp_index, expIdx);
    @(posedge clk);
    #1 checkOutput("rsp_pulse_one_cycle", rsp_valid, 1'b0);
  endtask

  task automatic changePin(input logic [15:0] pin, input logic expOk);
    @(negedge clk);
    chg_new_pin = pin;
    chg_valid   = 1'b1;
    @(posedge clk);
    #1 chg_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("chg_done", chg_done, 1'b1);
    checkOutput("chg_ok", chg_ok, expOk);
  endtask

  task automatic doLogout();
    @(negedge clk);
    logout = 1'b1;
    @(posedge clk);
    #1 logout = 1'b0;
    checkOutput("logout_session", session_active, 1'b0);
  endtask

  initial begin
    int rspBefore, chgBefore;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_req_ready", req_ready, 1'b0);
    checkOutput("reset_session", session_active, 1'b0);
    checkOutput("reset_chg_done", chg_done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("ready_after_reset", req_ready, 1'b1);

    applyStimulus(4'd3, 16'h3456, 5, 1'b1, 1'b1, 1'b0, 4'd2);
    checkOutput("session_acc3", session_active, 1'b1);
    checkOutput("session_idx_acc3", session_idx, 4'd2);

    applyStimulus(4'd12, 16'h3456, 12, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("session_cleared", session_active, 1'b0);
    applyStimulus(4'd0, 16'h0000, 12, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'd10, 16'h7123, 12, 1'b1, 1'b1, 1'b0, 4'd9);

    // Lockout on account 5.
    applyStimulus(4'd5, 16'h0000, 7, 1'b1, 1'b0, 1'b0, 4'd4);
    applyStimulus(4'd5, 16'h0000, 7, 1'b1, 1'b0, 1'b0, 4'd4);
    applyStimulus(4'd5, 16'h0000, 7, 1'b1, 1'b0, 1'b1, 4'd4);
    applyStimulus(4'd5, 16'h5678, 7, 1'b1, 1'b0, 1'b1, 4'd4);
    checkOutput("locked_no_session", session_active, 1'b0);

    // PIN change flow on account 1.
    applyStimulus(4'd1, 16'h1234, 3, 1'b1, 1'b1, 1'b0, 4'd0);
    changePin(16'h1234, 1'b0);
    changePin(16'h4321, 1'b1);
    checkOutput("session_kept", session_active, 1'b1);
    doLogout();
    applyStimulus(4'd1, 16'h4321, 3, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(4'd1, 16'h1234, 3, 1'b1, 1'b0, 1'b0, 4'd0);
    changePin(16'h1111, 1'b0);

    // Logout while in CHANGE refuses the change.
    applyStimulus(4'd1, 16'h4321, 3, 1'b1, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    chg_new_pin = 16'h2222;
    chg_valid   = 1'b1;
    @(posedge clk);
    #1 chg_valid = 1'b0;
    logout = 1'b1;
    @(posedge clk);
    #1 logout = 1'b0;
    checkOutput("logout_chg_done", chg_done, 1'b1);
    checkOutput("logout_chg_ok", chg_ok, 1'b0);
    checkOutput("logout_chg_session", session_active, 1'b0);
    applyStimulus(4'd1, 16'h4321, 3, 1'b1, 1'b1, 1'b0, 4'd0);

    // Request and change together: request wins, change dropped.
    chgBefore = chgCount;
    chg_new_pin = 16'h9999;
    chg_valid   = 1'b1;
    applyStimulus(4'd2, 16'h2345, 4, 1'b1, 1'b1, 1'b0, 4'd1);
    chg_valid = 1'b0;
    checkOutput("req_wins_no_chg", chgCount, chgBefore);
    checkOutput("req_wins_session_idx", session_idx, 4'd1);

    // Reset during SEARCH aborts silently and restores defaults.
    @(negedge clk);
    req_acc_num = 4'd10;
    req_pin     = 16'h7123;
    req_valid   = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rspBefore = rspCount;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("midreset_session", session_active, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 checkOutput("midreset_no_rsp", rspCount, rspBefore);
    applyStimulus(4'd1, 16'h1234, 3, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(4'd5, 16'h5678, 7, 1'b1, 1'b1, 1'b0, 4'd4);

`ifdef ADMIN_UNLOCK_EN
    applyStimulus(4'd5, 16'h0000, 7, 1'b1, 1'b0, 1'b0, 4'd4);
    applyStimulus(4'd5, 16'h0000, 7, 1'b1, 1'b0, 1'b0, 4'd4);
    applyStimulus(4'd5, 16'h0000, 7, 1'b1, 1'b0, 1'b1, 4'd4);
    @(negedge clk);
    unlock_idx   = 4'd12;
    unlock_valid = 1'b1;
    @(posedge clk);
    #1 unlock_valid = 1'b0;
    applyStimulus(4'd5, 16'h5678, 7, 1'b1, 1'b0, 1'b1, 4'd4);
    @(negedge clk);
    unlock_idx   = 4'd4;
    unlock_valid = 1'b1;
    @(posedge clk);
    #1 unlock_valid = 1'b0;
    applyStimulus(4'd5, 16'h5678, 7, 1'b1, 1'b1, 1'b0, 4'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
